traffic_light_monitor: RTL and testbench

TRAFFIC_LIGHT_MONITOR -- requirements
Module: traffic_light_monitor

---
 rtl/traffic_light_monitor_if.sv | 25 ++
 rtl/traffic_light_monitor.sv | 131 +++++++++++++
 tb/tb_traffic_light_monitor.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/traffic_light_monitor_if.sv
// Lamp inputs, clear and status outputs of the traffic light monitor.
// The master side drives the lamps and clear; the slave side is the monitor.
interface traffic_light_monitor_if #(
    parameter int CYCLE_W = 8
);
    logic               red;
    logic               amber;
    logic               green;
    logic               clear;
    logic               err;
    logic [1:0]         err_code;
    logic               err_pulse;
    logic [CYCLE_W-1:0] cycles;
    logic               in_sync;

    modport master (
        output red, amber, green, clear,
        input  err, err_code, err_pulse, cycles, in_sync
    );

    modport slave (
        input  red, amber, green, clear,
        output err, err_code, err_pulse, cycles, in_sync
    );
endinterface

// File: rtl/traffic_light_monitor.sv
// Watches the {red,amber,green} lamp pattern of a traffic light and checks
// it follows R -> RA -> G -> A -> R with no state lasting longer than
// MAX_DWELL samples. Reports a sticky first-error code, a per-error strobe
// and a count of completed cycles (amber-to-red transitions).
module traffic_light_monitor #(
    parameter int MAX_DWELL = 8,
    parameter int CYCLE_W   = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    traffic_light_monitor_if.slave  bus
);
    // Dwell must hold MAX_DWELL and still compare against it without wrapping.
    localparam int DWELL_W = $clog2(MAX_DWELL + 2);

    typedef enum logic [2:0] {
        S_SYNC = 3'd0,
        S_R    = 3'd1,
        S_RA   = 3'd2,
        S_G    = 3'd3,
        S_A    = 3'd4
    } state_t;

    localparam logic [1:0] CODE_PATTERN    = 2'd1;
    localparam logic [1:0] CODE_TRANSITION = 2'd2;
    localparam logic [1:0] CODE_DWELL      = 2'd3;

    state_t               state_reg;
    logic [DWELL_W-1:0]   dwell_reg;
    logic                 err_reg;
    logic [1:0]           err_code_reg;
    logic                 err_pulse_reg;
    logic [CYCLE_W-1:0]   cycles_reg;
    logic                 in_sync_reg;

    logic [2:0]           pattern;
    state_t               pattern_state;
    state_t               succ_state;
    logic [1:0]           fault_code;

    assign pattern = {bus.red, bus.amber, bus.green};

    // Decode the sampled lamps into the state they denote (SYNC = illegal)
    // and find which state legally follows the current one.
    always_comb begin
        pattern_state = S_SYNC;
        case (pattern)
            3'b100:  pattern_state = S_R;
            3'b110:  pattern_state = S_RA;
            3'b001:  pattern_state = S_G;
            3'b010:  pattern_state = S_A;
            default: pattern_state = S_SYNC;
        endcase
        succ_state = S_SYNC;
        case (state_reg)
            S_R:     succ_state = S_RA;
            S_RA:    succ_state = S_G;
            S_G:     succ_state = S_A;
            S_A:     succ_state = S_R;
            default: succ_state = S_SYNC;
        endcase
    end

    // Classify this sample: 0 means acceptable, otherwise the error code.
    // All-dark is tolerated only while hunting for a first legal pattern.
    always_comb begin
        fault_code = 2'd0;
        if (state_reg == S_SYNC) begin
            if (pattern_state == S_SYNC && pattern != 3'b000)
                fault_code = CODE_PATTERN;
        end else if (pattern_state == S_SYNC) begin
            fault_code = CODE_PATTERN;
        end else if (pattern_state == state_reg) begin
            if (dwell_reg >= DWELL_W'(MAX_DWELL))
                fault_code = CODE_DWELL;
        end else if (pattern_state != succ_state) begin
            fault_code = CODE_TRANSITION;
        end
    end

    // Sequence tracker with registered status outputs; clear outranks any
    // error seen on the same edge, and cycles survive clear and errors.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= S_SYNC;
            dwell_reg     <= '0;
            err_reg       <= 1'b0;
            err_code_reg  <= 2'd0;
            err_pulse_reg <= 1'b0;
            cycles_reg    <= '0;
            in_sync_reg   <= 1'b0;
        end else begin
            err_pulse_reg <= 1'b0;
            if (bus.clear) begin
                state_reg    <= S_SYNC;
                dwell_reg    <= '0;
                err_reg      <= 1'b0;
                err_code_reg <= 2'd0;
                in_sync_reg  <= 1'b0;
            end else if (fault_code != 2'd0) begin
                state_reg     <= S_SYNC;
                dwell_reg     <= '0;
                err_pulse_reg <= 1'b1;
                in_sync_reg   <= 1'b0;
                if (!err_reg) begin
                    err_reg      <= 1'b1;
                    err_code_reg <= fault_code;
                end
            end else if (state_reg == S_SYNC) begin
                if (pattern_state != S_SYNC) begin
                    state_reg   <= pattern_state;
                    dwell_reg   <= DWELL_W'(1);
                    in_sync_reg <= 1'b1;
                end
            end else if (pattern_state == state_reg) begin
                dwell_reg <= dwell_reg + DWELL_W'(1);
            end else begin
                state_reg <= pattern_state;
                dwell_reg <= DWELL_W'(1);
                if (state_reg == S_A)
                    cycles_reg <= cycles_reg + CYCLE_W'(1);
            end
        end
    end

    assign bus.err       = err_reg;
    assign bus.err_code  = err_code_reg;
    assign bus.err_pulse = err_pulse_reg;
    assign bus.cycles    = cycles_reg;
    assign bus.in_sync   = in_sync_reg;
endmodule

// File: tb/tb_traffic_light_monitor.sv
// Bench for traffic_light_monitor: a sequence-index model checked on every
// falling edge, plus hand-computed literal expectations along the way.
module tb_traffic_light_monitor;
    localparam int MD = 8;
    localparam int CW = 2;

    logic clk;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;

    traffic_light_monitor_if #(.CYCLE_W(CW)) bus ();

    traffic_light_monitor #(.MAX_DWELL(MD), .CYCLE_W(CW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // phase: 0 = hunting, 1..4 = position in the R,RA,G,A cycle
    typedef struct packed {
        logic [2:0]  phase;
        logic [15:0] dwell;
        logic        err;
        logic [1:0]  code;
        logic        pulse;
        logic [15:0] cycles;
    } mstate_t;

    mstate_t m;

    function automatic mstate_t mstep(mstate_t s, logic [2:0] p, logic c);
        mstate_t n;
        int      legal_pat [4];
        int      pos;
        int      ecode;
        legal_pat = '{4, 6, 1, 2};
        n = s;
        n.pulse = 1'b0;
        if (c) begin
            n.phase = 0; n.dwell = 0; n.err = 1'b0; n.code = 0;
            return n;
        end
        pos = 0;
        for (int k = 0; k < 4; k++)
            if (int'(p) == legal_pat[k]) pos = k + 1;
        ecode = 0;
        if (s.phase == 0) begin
            if (pos != 0) begin n.phase = 3'(pos); n.dwell = 1; end
            else if (p != 3'b000) ecode = 1;
        end else if (pos == 0) begin
            ecode = 1;
        end else if (pos == int'(s.phase)) begin
            if (int'(s.dwell) + 1 > MD) ecode = 3;
            else n.dwell = s.dwell + 1;
        end else if (pos == (int'(s.phase) % 4) + 1) begin
            if (s.phase == 4) n.cycles = 16'((int'(s.cycles) + 1) % (1 << CW));
            n.phase = 3'(pos);
            n.dwell = 1;
        end else begin
            ecode = 2;
        end
        if (ecode != 0) begin
            n.phase = 0; n.dwell = 0; n.pulse = 1'b1;
            if (!s.err) begin n.err = 1'b1; n.code = 2'(ecode); end
        end
        return n;
    endfunction

    // Model advances on the same edges as the DUT and resets with it.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) m <= '0;
        else        m <= mstep(m, {bus.red, bus.amber, bus.green}, bus.clear);
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Model comparison, away from the active edge.
    always @(negedge clk) begin
        chk("model_err",       int'(bus.err),       int'(m.err));
        chk("model_err_code",  int'(bus.err_code),  int'(m.code));
        chk("model_err_pulse", int'(bus.err_pulse), int'(m.pulse));
        chk("model_cycles",    int'(bus.cycles),    int'(m.cycles));
        chk("model_in_sync",   int'(bus.in_sync),   int'(m.phase != 0));
    end

    task automatic step(input logic [2:0] p, input logic c);
        @(negedge clk);
        {bus.red, bus.amber, bus.green} = p;
        bus.clear = c;
        @(posedge clk);
        #1;
        $display("t=%0t pat=%b clear=%b -> err=%b code=%0d pulse=%b cycles=%0d in_sync=%b",
                 $time, p, c, bus.err, bus.err_code, bus.err_pulse, bus.cycles, bus.in_sync);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_err"},       int'(bus.err),       0);
        chk({tag, "_err_code"},  int'(bus.err_code),  0);
        chk({tag, "_err_pulse"}, int'(bus.err_pulse), 0);
        chk({tag, "_cycles"},    int'(bus.cycles),    0);
        chk({tag, "_in_sync"},   int'(bus.in_sync),   0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int exp_cyc [5];
        exp_cyc = '{1, 2, 3, 0, 1};
        rst_n = 1'b0;
        bus.red = 1'b0; bus.amber = 1'b0; bus.green = 1'b0; bus.clear = 1'b0;
        #3;
        chk_all_zero("reset");
        #9 rst_n = 1'b1;

        // Dark lamps then one full legal cycle
        repeat (5) step(3'b000, 1'b0);
        chk("dark_in_sync", int'(bus.in_sync), 0);
        step(3'b100, 1'b0);
        chk("first_r_in_sync", int'(bus.in_sync), 1);
        step(3'b110, 1'b0);
        step(3'b001, 1'b0);
        step(3'b010, 1'b0);
        step(3'b100, 1'b0);
        chk("seq_cycles", int'(bus.cycles), 1);
        chk("seq_err", int'(bus.err), 0);

        // R followed by G is a skipped step
        step(3'b001, 1'b0);
        chk("skip_pulse", int'(bus.err_pulse), 1);
        chk("skip_err", int'(bus.err), 1);
        chk("skip_code", int'(bus.err_code), 2);
        chk("skip_in_sync", int'(bus.in_sync), 0);
        step(3'b000, 1'b0);
        chk("skip_pulse_gone", int'(bus.err_pulse), 0);

        // Illegal patterns from G; later errors leave the first code
        step(3'b000, 1'b1);
        chk("clear_err", int'(bus.err), 0);
        step(3'b100, 1'b0);
        step(3'b110, 1'b0);
        step(3'b001, 1'b0);
        step(3'b101, 1'b0);
        chk("illegal_code", int'(bus.err_code), 1);
        chk("illegal_pulse", int'(bus.err_pulse), 1);
        step(3'b011, 1'b0);
        chk("illegal2_pulse", int'(bus.err_pulse), 1);
        chk("illegal2_code", int'(bus.err_code), 1);
        step(3'b100, 1'b0);
        step(3'b001, 1'b0);
        chk("sticky_pulse", int'(bus.err_pulse), 1);
        chk("sticky_code", int'(bus.err_code), 1);

        // Dwell limit
        step(3'b000, 1'b1);
        repeat (MD) step(3'b100, 1'b0);
        chk("dwell_max_err", int'(bus.err), 0);
        chk("dwell_max_in_sync", int'(bus.in_sync), 1);
        step(3'b100, 1'b0);
        chk("dwell_over_code", int'(bus.err_code), 3);
        chk("dwell_over_pulse", int'(bus.err_pulse), 1);
        chk("dwell_over_in_sync", int'(bus.in_sync), 0);

        // Clear wins over a simultaneous illegal pattern
        step(3'b111, 1'b1);
        chk("clr_err", int'(bus.err), 0);
        chk("clr_code", int'(bus.err_code), 0);
        chk("clr_pulse", int'(bus.err_pulse), 0);
        step(3'b100, 1'b0);
        chk("clr_then_r", int'(bus.in_sync), 1);

        // Cycle counter wrap, starting from reset
        @(posedge clk); #3 rst_n = 1'b0;
        #4 rst_n = 1'b1;
        step(3'b100, 1'b0);
        chk("wrap_start", int'(bus.cycles), 0);
        for (int i = 0; i < 5; i++) begin
            step(3'b110, 1'b0);
            step(3'b001, 1'b0);
            step(3'b010, 1'b0);
            step(3'b100, 1'b0);
            chk($sformatf("wrap_cycles_%0d", i), int'(bus.cycles), exp_cyc[i]);
        end

        // Asynchronous reset mid-sequence, then resume from hunting
        step(3'b110, 1'b0);
        step(3'b001, 1'b0);
        #2 rst_n = 1'b0;
        #1 chk_all_zero("async_rst");
        @(negedge clk); #2 rst_n = 1'b1;
        step(3'b001, 1'b0);
        chk("resume_pulse", int'(bus.err_pulse), 0);
        chk("resume_err", int'(bus.err), 0);
        chk("resume_in_sync", int'(bus.in_sync), 1);
        step(3'b010, 1'b0);
        step(3'b100, 1'b0);
        chk("resume_cycles", int'(bus.cycles), 1);

        @(negedge clk);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
